// File: rtl/pipe_pkg.sv
// Shared pipeline definitions.
//   NOP_INSTR      : all-zeros instruction that fills a pipeline bubble.
//   *_DEF          : default datapath widths.
//   br_cond_e      : branch-logic condition encodings.
//   pc_sel_e       : PC next-value source selected by the fetch stage.
//   ifid_op_e      : IF/ID register action for the coming edge.
package pipe_pkg;

    localparam int PC_W_DEF    = 32;
    localparam int INSTR_W_DEF = 32;
    localparam int REG_ID_W    = 6;

    localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = '0;

    typedef enum logic [1:0] {
        BR_NONE   = 2'b00,
        BR_Z      = 2'b01,
        BR_N      = 2'b10,
        BR_ALWAYS = 2'b11
    } br_cond_e;

    typedef enum logic [1:0] {
        PC_HOLD   = 2'b00,
        PC_SEQ    = 2'b01,
        PC_BRANCH = 2'b10
    } pc_sel_e;

    typedef enum logic [1:0] {
        IFID_HOLD   = 2'b00,
        IFID_LOAD   = 2'b01,
        IFID_BUBBLE = 2'b10
    } ifid_op_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk   : clock, rising edge
//   clr   : synchronous clear (wins over inc)
//   inc   : add one this edge unless already at all ones
//   count : current value
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
//   CLK, RST     : clock and synchronous active-high reset
//   PC_Write     : 1 = PC may advance, 0 = hold (hazard stall)
//   IF_ID_Write  : 1 = IF/ID loads, 0 = IF/ID holds
//   Flush        : load a bubble into IF/ID
//   BrTaken      : taken branch, redirect PC to BrTarget (also bubbles IF/ID)
//   IMem_Addr    : instruction-memory address (the PC)
//   IMem_Data    : instruction read combinationally at IMem_Addr
//   PC_ID, Instr_ID, Valid_ID : IF/ID contents for decode
//   StallCount   : saturating count of stalled, non-redirected cycles
//   FlushCount   : saturating count of IF/ID flushes
module if_stage
    import pipe_pkg::*;
#(
    parameter int                 PC_W     = PC_W_DEF,
    parameter int                 INSTR_W  = INSTR_W_DEF,
    parameter logic [PC_W-1:0]    RESET_PC = '0,
    parameter int                 PC_STEP  = 1,
    parameter int                 CNT_W    = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               PC_Write,
    input  logic               IF_ID_Write,
    input  logic               Flush,
    input  logic               BrTaken,
    input  logic [PC_W-1:0]    BrTarget,
    output logic [PC_W-1:0]    IMem_Addr,
    input  logic [INSTR_W-1:0] IMem_Data,
    output logic [PC_W-1:0]    PC_ID,
    output logic [INSTR_W-1:0] Instr_ID,
    output logic               Valid_ID,
    output logic [CNT_W-1:0]   StallCount,
    output logic [CNT_W-1:0]   FlushCount
);

    logic [PC_W-1:0] pc;
    pc_sel_e         pc_sel;
    ifid_op_e        ifid_op;
    logic            stall_inc;
    logic            flush_inc;

    assign IMem_Addr = pc;

    // Control decode. A redirect beats a stall so a resolved branch is never
    // dropped, and a flush beats an IF/ID hold.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        pc_sel  = PC_HOLD;
        ifid_op = IFID_HOLD;

        if (BrTaken) begin
            pc_sel = PC_BRANCH;
        end else if (PC_Write) begin
            pc_sel = PC_SEQ;
        end

        if (Flush || BrTaken) begin
            ifid_op = IFID_BUBBLE;
        end else if (IF_ID_Write) begin
            ifid_op = IFID_LOAD;
        end
    end

    assign stall_inc = !PC_Write && !BrTaken;
    assign flush_inc = Flush || BrTaken;

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc <= RESET_PC;
        end else begin
            unique case (pc_sel)
                PC_BRANCH: pc <= BrTarget;
                PC_SEQ:    pc <= pc + PC_W'(PC_STEP);  // wraps modulo 2^PC_W
                default:   pc <= pc;
            endcase
        end
    end

    // IF/ID register. Reset takes precedence, so IMem_Data never reaches the
    // outputs while RST is high.
    always_ff @(posedge CLK) begin
        if (RST) begin
            PC_ID    <= '0;
            Instr_ID <= INSTR_W'(NOP_INSTR);
            Valid_ID <= 1'b0;
        end else begin
            unique case (ifid_op)
                IFID_BUBBLE: begin
                    PC_ID    <= '0;
                    Instr_ID <= INSTR_W'(NOP_INSTR);
                    Valid_ID <= 1'b0;
                end
                IFID_LOAD: begin
                    PC_ID    <= pc;
                    Instr_ID <= IMem_Data;
                    Valid_ID <= 1'b1;
                end
                default: begin
                    PC_ID    <= PC_ID;
                    Instr_ID <= Instr_ID;
                    Valid_ID <= Valid_ID;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (CLK),
        .clr   (RST),
        .inc   (stall_inc),
        .count (StallCount)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (CLK),
        .clr   (RST),
        .inc   (flush_inc),
        .count (FlushCount)
    );

endmodule
